// File: rtl/cache_line_xfer_if.sv
// rtl/cache_line_xfer_if.sv - memory-side burst bus of the cache line transfer engine
interface cache_line_xfer_if #(
    parameter int MEM_AW = 21
);
    logic              mem_req;
    logic              mem_wr;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_wdata;
    logic              mem_wvalid;
    logic              mem_wready;
    logic [31:0]       mem_rdata;
    logic              mem_rvalid;

    modport master (
        output mem_req, mem_wr, mem_addr, mem_wdata, mem_wvalid,
        input  mem_ack, mem_wready, mem_rdata, mem_rvalid
    );
    modport slave (
        input  mem_req, mem_wr, mem_addr, mem_wdata, mem_wvalid,
        output mem_ack, mem_wready, mem_rdata, mem_rvalid
    );
endinterface

// File: rtl/cache_line_xfer.sv
// rtl/cache_line_xfer.sv - fills or writes back one cache line over cache port B
module cache_line_xfer #(
    parameter int LINE_WORDS = 8,
    parameter int ADDR_W     = 12,
    parameter int MEM_AW     = 21,
    parameter int RD_LAT     = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  cmd_valid,
    output logic                                  cmd_ready,
    input  logic                                  cmd_wb,
    input  logic [ADDR_W-$clog2(LINE_WORDS)-1:0]  cmd_line,
    input  logic [MEM_AW-1:0]                     cmd_maddr,
    output logic                                  done,
    output logic                                  enb,
    output logic [3:0]                            web,
    output logic [ADDR_W-1:0]                     addrb,
    output logic [31:0]                           dinb,
    input  logic [31:0]                           doutb,
    cache_line_xfer_if.master                     mem
);
    localparam int WB    = $clog2(LINE_WORDS);
    localparam int LW    = ADDR_W - WB;
    localparam int CW    = WB + 1;
    localparam int DEPTH = RD_LAT + 1;
    localparam int PW    = $clog2(DEPTH);
    localparam int NW    = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_FILL, S_WBACK, S_DONE} state_t;

    state_t            state, state_nx;
    logic [LW-1:0]     line_q;
    logic [MEM_AW-1:0] maddr_q;
    logic              wb_q;
    logic [CW-1:0]     wcnt, scnt;
    logic [RD_LAT-1:0] vpipe;
    logic [31:0]       fifo_mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [NW-1:0]     fifo_count, inflight;
    logic [NW:0]       occ;
    logic              fifo_empty, head_vld, wvalid;
    logic              issue, fill_wr, push, pop, hs;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) inflight = inflight + NW'(vpipe[i]);
    end

    assign occ        = {1'b0, fifo_count} + {1'b0, inflight};
    assign fifo_empty = (fifo_count == '0);
    assign head_vld   = vpipe[RD_LAT-1];
    assign mem.mem_wr   = wb_q;
    assign mem.mem_addr = maddr_q;

    always_comb begin
        state_nx       = state;
        cmd_ready      = 1'b0;
        done           = 1'b0;
        enb            = 1'b0;
        web            = 4'h0;
        addrb          = '0;
        dinb           = '0;
        mem.mem_req    = 1'b0;
        mem.mem_wdata  = '0;
        wvalid         = 1'b0;
        issue          = 1'b0;
        fill_wr        = 1'b0;
        push           = 1'b0;
        pop            = 1'b0;
        hs             = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nx = S_REQ;
            end
            S_REQ: begin
                mem.mem_req = 1'b1;
                if (mem.mem_ack) state_nx = wb_q ? S_WBACK : S_FILL;
            end
            S_FILL: begin
                if (mem.mem_rvalid) begin
                    fill_wr = 1'b1;
                    enb     = 1'b1;
                    web     = 4'hF;
                    addrb   = {line_q, wcnt[WB-1:0]};
                    dinb    = mem.mem_rdata;
                    if (wcnt == CW'(LINE_WORDS - 1)) state_nx = S_DONE;
                end
            end
            S_WBACK: begin
                // reads in flight are counted against the skid space so a stalled sink never overflows it
                issue = !wcnt[WB] && (occ < (NW+1)'(DEPTH));
                if (issue) begin
                    enb   = 1'b1;
                    addrb = {line_q, wcnt[WB-1:0]};
                end
                // an empty FIFO lets the arriving read word straight through
                wvalid = !fifo_empty || head_vld;
                if (wvalid) mem.mem_wdata = fifo_empty ? doutb : fifo_mem[rd_ptr];
                hs   = wvalid && mem.mem_wready;
                pop  = hs && !fifo_empty;
                push = head_vld && !(hs && fifo_empty);
                if (hs && scnt == CW'(LINE_WORDS - 1)) state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign mem.mem_wvalid = wvalid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            line_q     <= '0;
            maddr_q    <= '0;
            wb_q       <= 1'b0;
            wcnt       <= '0;
            scnt       <= '0;
            vpipe      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            state <= state_nx;
            if (cmd_ready && cmd_valid) begin
                line_q     <= cmd_line;
                maddr_q    <= cmd_maddr;
                wb_q       <= cmd_wb;
                wcnt       <= '0;
                scnt       <= '0;
                vpipe      <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
            end else begin
                if (fill_wr || issue) wcnt <= wcnt + 1'b1;
                if (hs) scnt <= scnt + 1'b1;
                vpipe <= RD_LAT'({vpipe, issue});
                if (push) wr_ptr <= ptr_inc(wr_ptr);
                if (pop) rd_ptr <= ptr_inc(rd_ptr);
                fifo_count <= fifo_count + NW'(push) - NW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= doutb;
    end
endmodule

// File: tb/tb_cache_line_xfer.sv
// tb/tb_cache_line_xfer.sv - directed checks of cache_line_xfer at RD_LAT 1, 2 and 3
`timescale 1ns/1ps
module tb_cache_line_xfer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, cmd_valid, cmd_wb, mem_ack, mem_wready, mem_rvalid, mon_clr;
    logic [8:0]  cmd_line;
    logic [20:0] cmd_maddr;
    logic [31:0] mem_rdata;

    logic [2:0]  cmd_ready_v, done_v, enb_v, mem_req_v, mem_wr_v, mem_wvalid_v;
    logic [3:0]  web_v [3];
    logic [11:0] addrb_v [3];
    logic [31:0] dinb_v [3];
    logic [31:0] mem_wdata_v [3];
    logic [20:0] mem_addr_v [3];

    int n_checks = 0;
    int n_errors = 0;

    int got_n [3], done_cnt [3], outst [3], max_out [3], first_wv [3], done_cyc [3], wr_cnt [3];
    logic [31:0] got_w [3][8];
    int cyc = 0;
    int ack_cyc = -1;

    function automatic logic [31:0] def_word(input logic [11:0] a);
        if (a[11:3] == 9'd5) return 32'hB0 + {29'd0, a[2:0]};
        return {20'hC0000, a};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gen_lat
        localparam int LAT = g + 1;
        cache_line_xfer_if #(.MEM_AW(21)) bus ();
        logic        enb;
        logic [3:0]  web;
        logic [11:0] addrb;
        logic [31:0] dinb, doutb;
        logic [31:0] cmem [4096];
        logic        wflag [4096];
        logic [31:0] rp [3];

        cache_line_xfer #(.LINE_WORDS(8), .ADDR_W(12), .MEM_AW(21), .RD_LAT(LAT)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_v[g]), .cmd_wb(cmd_wb),
            .cmd_line(cmd_line), .cmd_maddr(cmd_maddr), .done(done_v[g]),
            .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb),
            .mem(bus)
        );

        assign bus.mem_ack    = mem_ack;
        assign bus.mem_wready = mem_wready;
        assign bus.mem_rdata  = mem_rdata;
        assign bus.mem_rvalid = mem_rvalid;
        assign enb_v[g]        = enb;
        assign web_v[g]        = web;
        assign addrb_v[g]      = addrb;
        assign dinb_v[g]       = dinb;
        assign mem_req_v[g]    = bus.mem_req;
        assign mem_wr_v[g]     = bus.mem_wr;
        assign mem_addr_v[g]   = bus.mem_addr;
        assign mem_wdata_v[g]  = bus.mem_wdata;
        assign mem_wvalid_v[g] = bus.mem_wvalid;

        always @(posedge clk) begin
            if (!rst_n) begin
                for (int k = 0; k < 4096; k++) wflag[k] <= 1'b0;
            end else if (enb && web != 4'h0) begin
                for (int b = 0; b < 4; b++) if (web[b]) cmem[addrb][8*b +: 8] <= dinb[8*b +: 8];
                wflag[addrb] <= 1'b1;
            end
            if (enb && web == 4'h0) rp[0] <= wflag[addrb] ? cmem[addrb] : def_word(addrb);
            rp[1] <= rp[0];
            rp[2] <= rp[1];
        end
        assign doutb = rp[LAT-1];
    end

    always @(negedge clk) begin
        if (mon_clr) begin
            for (int i = 0; i < 3; i++) begin
                got_n[i] = 0; done_cnt[i] = 0; outst[i] = 0; max_out[i] = 0;
                first_wv[i] = -1; done_cyc[i] = -1; wr_cnt[i] = 0;
            end
            ack_cyc = -1;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (enb_v[i] && web_v[i] == 4'h0) outst[i]++;
                if (outst[i] > max_out[i]) max_out[i] = outst[i];
                if (mem_wvalid_v[i] && mem_wready) begin
                    if (got_n[i] < 8) got_w[i][got_n[i]] = mem_wdata_v[i];
                    got_n[i]++;
                    outst[i]--;
                    if (first_wv[i] < 0) first_wv[i] = cyc;
                end
                if (done_v[i]) begin
                    done_cnt[i]++;
                    done_cyc[i] = cyc;
                end
                if (enb_v[i] && web_v[i] != 4'h0) wr_cnt[i]++;
            end
            if (mem_req_v[0] && mem_ack && ack_cyc < 0) ack_cyc = cyc;
        end
        cyc++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit all_done();
        return done_cnt[0] > 0 && done_cnt[1] > 0 && done_cnt[2] > 0;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int w;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_wb = 1'b0; cmd_line = '0; cmd_maddr = '0;
        mem_ack = 1'b0; mem_wready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mon_clr = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            check("rst_cmd_ready", 64'(cmd_ready_v[i]), 64'd1);
            check("rst_ctl", 64'({done_v[i], enb_v[i], web_v[i], mem_req_v[i], mem_wr_v[i],
                                  mem_wvalid_v[i], addrb_v[i], mem_addr_v[i]}), 64'd0);
            check("rst_data", {dinb_v[i], mem_wdata_v[i]}, 64'd0);
        end
        rst_n = 1'b1; mon_clr = 1'b0;
        tick();

        // fill line 3 from maddr 0x100, one idle rvalid gap mid-line
        cmd_valid = 1'b1; cmd_wb = 1'b0; cmd_line = 9'd3; cmd_maddr = 21'h100; #1;
        for (int i = 0; i < 3; i++) check("fill_accept", 64'(cmd_ready_v[i]), 64'd1);
        tick();
        cmd_valid = 1'b0; mem_ack = 1'b1; #1;
        for (int i = 0; i < 3; i++)
            check("fill_req", 64'({mem_req_v[i], mem_wr_v[i], mem_addr_v[i], enb_v[i], cmd_ready_v[i]}),
                  64'({1'b1, 1'b0, 21'h100, 1'b0, 1'b0}));
        tick();
        mem_ack = 1'b0;
        w = 0;
        for (int k = 0; k < 9; k++) begin
            if (k == 4) begin
                mem_rvalid = 1'b0; #1;
                for (int i = 0; i < 3; i++) check("fill_gap_enb", 64'(enb_v[i]), 64'd0);
            end else begin
                mem_rvalid = 1'b1; mem_rdata = 32'hA0 + w; #1;
                for (int i = 0; i < 3; i++)
                    check("fill_wr", 64'({enb_v[i], web_v[i], addrb_v[i], dinb_v[i]}),
                          64'({1'b1, 4'hF, 12'(24 + w), 32'(32'hA0 + w)}));
                w++;
            end
            tick();
        end
        mem_rvalid = 1'b0; #1;
        for (int i = 0; i < 3; i++) check("fill_done", 64'({done_v[i], cmd_ready_v[i], enb_v[i]}), 64'b100);
        tick();
        for (int i = 0; i < 3; i++) check("fill_idle", 64'({done_v[i], cmd_ready_v[i]}), 64'b01);

        // writeback line 5 with mem_ack held off 10 cycles, sink always ready
        cmd_valid = 1'b1; cmd_wb = 1'b1; cmd_line = 9'd5; cmd_maddr = 21'h1ABCD; mem_wready = 1'b1;
        tick();
        cmd_valid = 1'b0; mon_clr = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            for (int i = 0; i < 3; i++)
                check("wb_req_hold", 64'({mem_req_v[i], mem_wr_v[i], mem_addr_v[i], enb_v[i]}),
                      64'({1'b1, 1'b1, 21'h1ABCD, 1'b0}));
            tick();
            mon_clr = 1'b0;
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        for (int k = 0; k < 40 && !all_done(); k++) tick();
        repeat (4) tick();
        for (int i = 0; i < 3; i++) begin
            check("wb5_count", 64'(got_n[i]), 64'd8);
            for (int j = 0; j < 8; j++) check("wb5_word", 64'(got_w[i][j]), 64'(32'hB0 + j));
            check("wb5_first_lat", 64'(first_wv[i] - ack_cyc), 64'(i + 2));
            check("wb5_done_lat", 64'(done_cyc[i] - ack_cyc), 64'(i + 10));
            check("wb5_done_once", 64'(done_cnt[i]), 64'd1);
            check("wb5_outstanding", 64'(max_out[i] <= i + 2), 64'd1);
        end

        // writeback of the freshly filled line 3 against a stalled then random sink
        cmd_valid = 1'b1; cmd_wb = 1'b1; cmd_line = 9'd3; cmd_maddr = 21'h33; mem_wready = 1'b0;
        tick();
        cmd_valid = 1'b0; mon_clr = 1'b1; mem_ack = 1'b1;
        tick();
        mon_clr = 1'b0; mem_ack = 1'b0;
        for (int k = 0; k < 300 && !all_done(); k++) begin
            mem_wready = (k < 6) ? 1'b0 : 1'($urandom_range(0, 1));
            tick();
        end
        mem_wready = 1'b1;
        repeat (4) tick();
        for (int i = 0; i < 3; i++) begin
            check("wb3_count", 64'(got_n[i]), 64'd8);
            for (int j = 0; j < 8; j++) check("wb3_word", 64'(got_w[i][j]), 64'(32'hA0 + j));
            check("wb3_done_once", 64'(done_cnt[i]), 64'd1);
            check("wb3_fifo_peak", 64'(max_out[i]), 64'(i + 2));
        end

        // cmd_valid held through a fill: the repeat is taken only after DONE
        mem_wready = 1'b0; cmd_valid = 1'b1; cmd_wb = 1'b0; cmd_line = 9'd7; cmd_maddr = 21'h55;
        tick();
        mem_ack = 1'b1; #1;
        for (int i = 0; i < 3; i++) check("hold_req_ready", 64'({mem_req_v[i], cmd_ready_v[i]}), 64'b10);
        tick();
        mem_ack = 1'b0;
        for (int k = 0; k < 8; k++) begin
            mem_rvalid = 1'b1; mem_rdata = 32'hC0 + k; #1;
            for (int i = 0; i < 3; i++) check("hold_busy", 64'({cmd_ready_v[i], mem_req_v[i]}), 64'b00);
            tick();
        end
        mem_rvalid = 1'b0; #1;
        for (int i = 0; i < 3; i++) check("hold_done", 64'({done_v[i], cmd_ready_v[i]}), 64'b10);
        tick();
        for (int i = 0; i < 3; i++) check("hold_reaccept", 64'({done_v[i], cmd_ready_v[i], mem_req_v[i]}), 64'b010);
        tick();
        cmd_valid = 1'b0; #1;
        for (int i = 0; i < 3; i++)
            check("hold_second_req", 64'({mem_req_v[i], mem_addr_v[i]}), 64'({1'b1, 21'h55}));

        // reset in the middle of the second fill, after four words
        mon_clr = 1'b1; mem_ack = 1'b1;
        tick();
        mon_clr = 1'b0; mem_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_rvalid = 1'b1; mem_rdata = 32'hD0 + k;
            tick();
        end
        mem_rdata = 32'hEE; rst_n = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_mid_ctl", 64'({enb_v[i], web_v[i], done_v[i], mem_req_v[i], cmd_ready_v[i], addrb_v[i]}),
                  64'({1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 12'h000}));
            check("rst_mid_data", {dinb_v[i], mem_wdata_v[i]}, 64'd0);
        end
        tick();
        tick();
        rst_n = 1'b1; #1;
        for (int i = 0; i < 3; i++) check("rst_release", 64'({cmd_ready_v[i], enb_v[i], web_v[i]}), 64'({1'b1, 1'b0, 4'h0}));
        tick();
        mem_rvalid = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) check("rst_cache_writes", 64'(wr_cnt[i]), 64'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
